// File: rtl/axi_stream_crc_pkg.sv
// axi_stream_crc_pkg: shared defaults, FSM state type and index helper for the CRC arbiter
package axi_stream_crc_pkg;
  localparam int DATA_WIDTH = 512;
  localparam int CRC_WIDTH = 32;
  localparam int KEEP_BYTES = DATA_WIDTH / 8;
  localparam int STAT_W = 16;
  typedef enum logic {IDLE, XFER} arb_state_t;
  function automatic int wrap_idx(int base, int off, int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/axi_stream_crc_arbiter_if.sv
// axi_stream_crc_arbiter_if: bundled source-side and appender-side AXI-Stream signals of the arbiter
// Ports: slave = arbiter view (sources + appender ready in, muxed stream/crc/grant/busy out);
//        master = environment view. o_pkt_cnt exists only with AXIS_CRC_ARB_STATS_EN.
interface axi_stream_crc_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_WIDTH = axi_stream_crc_pkg::DATA_WIDTH,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH = axi_stream_crc_pkg::CRC_WIDTH
);
  import axi_stream_crc_pkg::*;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_s_tdata;
  logic [NUM_SRC*KEEP_BYTES-1:0] i_s_tkeep;
  logic [NUM_SRC-1:0] i_s_tlast;
  logic [NUM_SRC-1:0] i_s_tvalid;
  logic [NUM_SRC-1:0] o_s_tready;
  logic [NUM_SRC*CRC_WIDTH-1:0] i_s_crc;
  logic [DATA_WIDTH-1:0] o_m_tdata;
  logic [KEEP_BYTES-1:0] o_m_tkeep;
  logic o_m_tlast;
  logic o_m_tvalid;
  logic i_m_tready;
  logic [CRC_WIDTH-1:0] o_crc;
  logic [NUM_SRC-1:0] o_grant;
  logic o_busy;
`ifdef AXIS_CRC_ARB_STATS_EN
  logic [NUM_SRC*STAT_W-1:0] o_pkt_cnt;
  modport slave(
    input i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tvalid, i_s_crc, i_m_tready,
    output o_s_tready, o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid, o_crc, o_grant, o_busy, o_pkt_cnt
  );
  modport master(
    output i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tvalid, i_s_crc, i_m_tready,
    input o_s_tready, o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid, o_crc, o_grant, o_busy, o_pkt_cnt
  );
`else
  modport slave(
    input i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tvalid, i_s_crc, i_m_tready,
    output o_s_tready, o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid, o_crc, o_grant, o_busy
  );
  modport master(
    output i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tvalid, i_s_crc, i_m_tready,
    input o_s_tready, o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid, o_crc, o_grant, o_busy
  );
`endif
endinterface

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin picker, first requester at or above ptr_i with wrap-around
// Ports: req_i requests, ptr_i priority start; grant_o one-hot, idx_o encoded winner, any_req_o any request.
module axis_rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] ptr_i,
  output logic [NUM_SRC-1:0]         grant_o,
  output logic [$clog2(NUM_SRC)-1:0] idx_o,
  output logic                       any_req_o
);
  import axi_stream_crc_pkg::*;
  localparam int IW = $clog2(NUM_SRC);
  // Scan from the farthest offset down so the closest requester to ptr_i is written last and wins.
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[wrap_idx(int'(ptr_i), i, NUM_SRC)]) begin
        grant_o = '0;
        grant_o[wrap_idx(int'(ptr_i), i, NUM_SRC)] = 1'b1;
        idx_o = IW'(wrap_idx(int'(ptr_i), i, NUM_SRC));
      end
    end
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/axi_stream_crc_arbiter.sv
// axi_stream_crc_arbiter: packet-level round-robin arbiter sharing one sideband-CRC appender among NUM_SRC sources
// Ports: clk, srst (async assert, active high), bus (slave modport): per-source streams + CRCs in,
//        one muxed stream, registered o_crc, one-hot o_grant and o_busy out.
// Optional: AXIS_CRC_ARB_STATS_EN adds o_pkt_cnt, one wrapping 16-bit completed-packet counter per source.
module axi_stream_crc_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_WIDTH = axi_stream_crc_pkg::DATA_WIDTH,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH = axi_stream_crc_pkg::CRC_WIDTH
) (
  input logic clk,
  input logic srst,
  axi_stream_crc_arbiter_if.slave bus
);
  import axi_stream_crc_pkg::*;
  localparam int IW = $clog2(NUM_SRC);
  arb_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, pick_idx;
  logic [NUM_SRC-1:0] grant_q, grant_d, pick_oh;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic any_req, xfer, eop;
  axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req_i    (bus.i_s_tvalid),
    .ptr_i    (rr_ptr_q),
    .grant_o  (pick_oh),
    .idx_o    (pick_idx),
    .any_req_o(any_req)
  );
  assign xfer = state_q == XFER;
  // Outside XFER the stream is forced to zero rather than showing the mux of a stale index.
  assign bus.o_m_tdata = xfer ? bus.i_s_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.o_m_tkeep = xfer ? bus.i_s_tkeep[gidx_q*KEEP_BYTES +: KEEP_BYTES] : '0;
  assign bus.o_m_tlast = xfer & bus.i_s_tlast[gidx_q];
  assign bus.o_m_tvalid = xfer & bus.i_s_tvalid[gidx_q];
  assign bus.o_s_tready = xfer ? grant_q & {NUM_SRC{bus.i_m_tready}} : '0;
  assign bus.o_crc = crc_q;
  assign bus.o_grant = grant_q;
  assign bus.o_busy = xfer;
  assign eop = bus.o_m_tvalid & bus.i_m_tready & bus.o_m_tlast;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d = gidx_q;
    grant_d = grant_q;
    crc_d = crc_q;
    if (!xfer && any_req) begin
      state_d = XFER;
      gidx_d = pick_idx;
      grant_d = pick_oh;
      crc_d = bus.i_s_crc[pick_idx*CRC_WIDTH +: CRC_WIDTH];
    end else if (eop) begin
      state_d = IDLE;
      grant_d = '0;
      rr_ptr_d = (int'(gidx_q) == NUM_SRC - 1) ? '0 : gidx_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gidx_q <= '0;
      grant_q <= '0;
      crc_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q <= gidx_d;
      grant_q <= grant_d;
      crc_q <= crc_d;
    end
  end
`ifdef AXIS_CRC_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_SRC];
  logic [STAT_W-1:0] cnt_d [NUM_SRC];
  always_comb begin
    cnt_d = cnt_q;
    if (eop) cnt_d[gidx_q] = cnt_q[gidx_q] + 1'b1;
  end
  always_ff @(posedge clk or posedge srst) begin
    if (srst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
    assign bus.o_pkt_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
  end
`endif
endmodule

// File: tb/tb_axi_stream_crc_arbiter.sv
// tb_axi_stream_crc_arbiter: randomized and directed bench with a packet-level round-robin reference model
module tb_axi_stream_crc_arbiter;
  localparam int NS = 4, DW = 32, KB = 4, CW = 32;
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;
  axi_stream_crc_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(CW)) bus ();
  axi_stream_crc_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(CW)) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );
  int checks = 0, errors = 0;
  logic [DW-1:0] bd [NS][8];
  logic [KB-1:0] bk [NS][8];
  logic [CW-1:0] bcrc [NS], fixcrc [NS];
  int blen [NS], bi [NS], left [NS], fixlen [NS];
  bit has [NS], hs [NS];
  bit vpat [NS][$];
  bit rpat [$];
  int vprob = 100, rprob = 100;
  bit mbusy = 0;
  int mg = 0, mrr = 0;
  logic [CW-1:0] mcrc = '0;
  logic [15:0] mcnt [NS];
  int gseq [$];

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endfunction

  function automatic void new_pkt(int k);
    blen[k] = fixlen[k] > 0 ? fixlen[k] : int'($urandom_range(1, 4));
    bcrc[k] = fixcrc[k] != 0 ? fixcrc[k] : $urandom;
    for (int b = 0; b < 8; b++) begin
      bd[k][b] = $urandom;
      bk[k][b] = KB'($urandom);
    end
    bi[k] = 0;
  endfunction

  function automatic void start(int k, int n, int len, logic [CW-1:0] crc);
    fixlen[k] = len;
    fixcrc[k] = crc;
    left[k] = n;
    has[k] = 1;
    new_pkt(k);
  endfunction

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      if (hs[k]) begin
        if (bi[k] == blen[k] - 1) begin
          left[k]--;
          if (left[k] > 0) new_pkt(k);
          else has[k] = 0;
        end else bi[k]++;
      end
      bus.i_s_tvalid[k] = has[k] && (vpat[k].size() > 0 ? vpat[k].pop_front() : ($urandom_range(1, 100) <= vprob));
      bus.i_s_tdata[k*DW +: DW] = has[k] ? bd[k][bi[k]] : '0;
      bus.i_s_tkeep[k*KB +: KB] = has[k] ? bk[k][bi[k]] : '0;
      bus.i_s_tlast[k] = has[k] && bi[k] == blen[k] - 1;
      bus.i_s_crc[k*CW +: CW] = has[k] ? bcrc[k] : '0;
    end
    bus.i_m_tready = rpat.size() > 0 ? rpat.pop_front() : ($urandom_range(1, 100) <= rprob);
  endtask

  function automatic void check();
    logic [NS-1:0] eg;
    eg = mbusy ? NS'(1) << mg : '0;
    chk("busy", bus.o_busy, mbusy);
    chk("grant", bus.o_grant, eg);
    chk("crc", bus.o_crc, mcrc);
    chk("m_tvalid", bus.o_m_tvalid, mbusy && bus.i_s_tvalid[mg]);
    chk("m_tdata", bus.o_m_tdata, mbusy ? bus.i_s_tdata[mg*DW +: DW] : '0);
    chk("m_tkeep", bus.o_m_tkeep, mbusy ? bus.i_s_tkeep[mg*KB +: KB] : '0);
    chk("m_tlast", bus.o_m_tlast, mbusy && bus.i_s_tlast[mg]);
    chk("s_tready", bus.o_s_tready, bus.i_m_tready ? eg : '0);
`ifdef AXIS_CRC_ARB_STATS_EN
    for (int k = 0; k < NS; k++) chk("pkt_cnt", bus.o_pkt_cnt[k*16 +: 16], mcnt[k]);
`endif
  endfunction

  function automatic void update();
    bit tv;
    for (int k = 0; k < NS; k++) hs[k] = 0;
    if (!mbusy) begin
      for (int i = 0; i < NS; i++)
        if (!mbusy && bus.i_s_tvalid[(mrr + i) % NS]) begin
          mg = (mrr + i) % NS;
          mbusy = 1;
          mcrc = bus.i_s_crc[mg*CW +: CW];
          gseq.push_back(mg);
        end
    end else begin
      tv = bus.i_s_tvalid[mg] && bus.i_m_tready;
      hs[mg] = tv;
      if (tv && bus.i_s_tlast[mg]) begin
        mbusy = 0;
        mrr = (mg + 1) % NS;
        mcnt[mg]++;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    check();
    update();
  endtask

  function automatic bit pending();
    bit p = mbusy;
    for (int k = 0; k < NS; k++) p |= has[k] | hs[k];
    return p;
  endfunction

  task automatic run_idle(int maxc);
    int c = 0;
    while (pending() && c < maxc) begin
      step();
      c++;
    end
    chk("drain_timeout", pending(), 0);
  endtask

  task automatic do_reset();
    srst = 1;
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_crc", bus.o_crc, 0);
    chk("rst_m_tvalid", bus.o_m_tvalid, 0);
    chk("rst_m_tlast", bus.o_m_tlast, 0);
    chk("rst_m_tdata", bus.o_m_tdata, 0);
    chk("rst_m_tkeep", bus.o_m_tkeep, 0);
    chk("rst_s_tready", bus.o_s_tready, 0);
    mbusy = 0;
    mrr = 0;
    mcrc = '0;
    for (int k = 0; k < NS; k++) begin
      mcnt[k] = '0;
      hs[k] = 0;
      bi[k] = 0;
    end
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    srst = 0;
    update();
  endtask

  function automatic void chk_seq(string n, int e[$]);
    chk(n, gseq.size(), e.size());
    foreach (e[i]) chk(n, i < gseq.size() ? gseq[i] : -1, e[i]);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NS; k++) begin
      mcnt[k] = '0;
      has[k] = 0;
      hs[k] = 0;
      blen[k] = 1;
      bi[k] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    chk("init_grant", bus.o_grant, 0);
    chk("init_crc", bus.o_crc, 0);
    srst = 0;
    update();
    // single 4-beat packet from source 0
    start(0, 1, 4, 32'hCECDCBCA);
    step();
    chk("t1_bubble_grant", bus.o_grant, 0);
    chk("t1_bubble_tvalid", bus.o_m_tvalid, 0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t1_grant", bus.o_grant, 4'b0001);
      chk("t1_crc", bus.o_crc, 32'hCECDCBCA);
      chk("t1_tvalid", bus.o_m_tvalid, 1);
      chk("t1_tlast", bus.o_m_tlast, b == 3);
    end
    step();
    chk("t1_idle_grant", bus.o_grant, 0);
    chk("t1_crc_hold", bus.o_crc, 32'hCECDCBCA);
    // simultaneous requests from reset pointer
    do_reset();
    gseq.delete();
    start(0, 1, 2, 32'hABCDEF45);
    start(1, 1, 2, 32'h12CDEF23);
    start(2, 1, 2, 32'h34CDEF11);
    run_idle(60);
    chk_seq("t2_order", '{0, 1, 2});
    chk("t2_last_crc", bus.o_crc, 32'h34CDEF11);
    // downstream backpressure
    rpat = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    start(0, 1, 3, 0);
    run_idle(40);
    // granted source drops valid while source 3 waits
    gseq.delete();
    vpat[1] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    start(1, 1, 4, 0);
    step();
    step();
    start(3, 1, 2, 0);
    step();
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t4_drop_tvalid", bus.o_m_tvalid, 0);
      chk("t4_drop_grant", bus.o_grant, 4'b0010);
    end
    run_idle(40);
    chk_seq("t4_order", '{1, 3});
    // reset mid-packet restores the pointer to source 0
    start(1, 1, 2, 0);
    run_idle(40);
    start(2, 1, 3, 0);
    step();
    step();
    step();
    chk("t5_mid_grant", bus.o_grant, 4'b0100);
    start(0, 1, 2, 0);
    gseq.delete();
    do_reset();
    run_idle(60);
    chk_seq("t5_order", '{0, 2});
`ifdef AXIS_CRC_ARB_STATS_EN
    do_reset();
    start(2, 3, 0, 0);
    run_idle(100);
    chk("t6_pkt_cnt", bus.o_pkt_cnt, 64'h0000_0003_0000_0000);
`endif
    // randomized traffic on all sources
    vprob = 75;
    rprob = 70;
    for (int k = 0; k < NS; k++) start(k, int'($urandom_range(3, 6)), 0, 0);
    run_idle(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_crc_arbiter.md
Name: axi_stream_crc_arbiter

Overview:
- Packet-level round-robin arbiter that shares one axi_stream_sideband_crc instance between NUM_SRC AXI-Stream sources.
- Each source presents a packet plus its sideband CRC.
- The arbiter locks onto one source for a whole packet, from grant to the tlast handshake.
- It forwards that source's beats unchanged and holds the granted CRC stable on o_crc for the full packet.
- Sits directly upstream of the CRC appender: o_m_* connect to the appender's i_s_*, and o_crc connects to its crc port.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..8).
- DATA_WIDTH, 512: tdata width in bits.
- KEEP_BYTES, DATA_WIDTH/8: tkeep width.
- CRC_WIDTH, 32: sideband CRC width.

Ports:
- clk  in  1  clock.
- srst  in  1  asynchronous, active-high reset.
- i_s_tdata  in  NUM_SRC*DATA_WIDTH  source data, source k at slice k.
- i_s_tkeep  in  NUM_SRC*KEEP_BYTES  source byte enables.
- i_s_tlast  in  NUM_SRC  source end-of-packet.
- i_s_tvalid  in  NUM_SRC  source valid; also acts as the request.
- o_s_tready  out  NUM_SRC  per-source ready.
- i_s_crc  in  NUM_SRC*CRC_WIDTH  per-source sideband CRC; must be valid whenever i_s_tvalid[k] is high on a first beat.
- o_m_tdata  out  DATA_WIDTH  to CRC appender.
- o_m_tkeep  out  KEEP_BYTES  to CRC appender.
- o_m_tlast  out  1  to CRC appender.
- o_m_tvalid  out  1  to CRC appender.
- i_m_tready  in  1  from CRC appender.
- o_crc  out  CRC_WIDTH  registered CRC of the granted packet.
- o_grant  out  NUM_SRC  one-hot current grant; 0 when idle.
- o_busy  out  1  high in XFER.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - o_grant=0, o_crc=0, o_busy=0.
  - o_s_tready=0, o_m_tvalid=0, o_m_tlast=0, o_m_tdata=0, o_m_tkeep=0.
  - A reset mid-packet abandons the packet. There is no recovery beat; the source must restart its packet.
- States: IDLE, XFER.
- IDLE:
  - If any i_s_tvalid is high, select the first asserted source scanning upward from rr_ptr, with wrap-around.
  - On the next edge: state=XFER, o_grant=onehot(sel), o_crc<=i_s_crc[sel], o_busy=1.
  - No beat is transferred in IDLE, so arbitration costs exactly one bubble cycle per packet.
- XFER (combinational path for the granted source g):
  - o_m_tdata/tkeep/tlast/tvalid = source g's signals.
  - o_s_tready[g] = i_m_tready; all other o_s_tready bits = 0.
  - When not in XFER, o_m_* are driven 0, not the muxed value.
- End of packet:
  - On o_m_tvalid & i_m_tready & o_m_tlast: next state=IDLE, rr_ptr=(g+1) mod NUM_SRC, o_grant=0, o_busy=0.
  - o_crc holds its value until the next grant.
- Mid-packet rules:
  - Granted source drops tvalid: stay in XFER, o_m_tvalid=0; other requesters are ignored (no preemption).
  - Downstream backpressure (i_m_tready=0): beat held, source stalled, no state change.
  - Single-beat packet (tlast on first beat): legal; returns to IDLE after that one handshake.
- Other requesters:
  - Requests arriving during XFER wait; they are considered only in IDLE.
  - Simultaneous requests are resolved purely by rr_ptr.
- Data is not modified: tkeep values, including all-zero, pass through.
- Latency: first beat reaches o_m one cycle after request (IDLE cycle); thereafter zero-latency passthrough.

Optional Feature:
- Macro: AXIS_CRC_ARB_STATS_EN.
- Defined:
  - Adds output o_pkt_cnt, width NUM_SRC*16.
  - One wrapping 16-bit counter per source, incremented on each completed tlast handshake of that source.
  - Reset to 0; 0xFFFF wraps to 0x0000.
- Not defined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package axi_stream_crc_pkg:
  - DATA_WIDTH, CRC_WIDTH, KEEP_BYTES defaults.
  - typedef enum logic {IDLE, XFER} arb_state_t.
  - STAT_W=16.
- Sub-module axis_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: onehot grant, encoded index, any_req.
- Top module holds the FSM, rr_ptr, CRC register, data mux and stats counters.

Test Plan:
- Single source 0 sends a 4-beat packet, crc=32'hCECDCBCA, i_m_tready=1:
  - 1 IDLE cycle, then 4 contiguous beats on o_m.
  - o_crc=CECDCBCA from grant through the tlast beat.
  - o_grant=4'b0001, then 0.
- Sources 0,1,2 request together with crcs ABCDEF45/12CDEF23/34CDEF11, 2-beat packets each:
  - Grant order 0,1,2, each separated by one bubble.
  - o_crc switches only at each grant.
- Backpressure: i_m_tready toggles 1,0,0,1 during a packet:
  - Beats held stable while stalled; no beat lost or duplicated.
  - Source o_s_tready mirrors i_m_tready.
- Source 3 requests mid-packet of source 1; source 1 drops tvalid for 2 cycles:
  - No switch; o_m_tvalid=0 for those 2 cycles.
  - Source 3 is granted after source 1's tlast.
- srst asserted on beat 2 of a 3-beat packet:
  - All outputs 0 immediately (async).
  - After release, next grant comes from source 0 (rr_ptr=0).
- With AXIS_CRC_ARB_STATS_EN, run 3 packets from source 2:
  - o_pkt_cnt slice 2 = 3, all other slices = 0.
